dmem_handshake_responder: RTL and testbench



---
 rtl/dmem_handshake_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_handshake_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_handshake_responder.sv
// Data-memory responder: request/ready handshake in front of a word-organised
// RAM, with a fixed number of wait states and misaligned/out-of-range checks.
module dmem_handshake_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_live;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_cur_we;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic [3:0]  w_cur_be;
    logic        w_cur_err;
    logic [31:0] w_off;
    logic        w_addr_err;
    logic [AW-1:0] w_idx;

    // Select the transaction being completed: live inputs when a zero-wait
    // request goes straight from IDLE to RESP, otherwise the latched copy.
    always_comb begin
        w_accept     = r_live && (r_state == ST_IDLE) && i_req;
        w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                       ((r_state == ST_WAIT) && (r_cnt == '0));
        if (r_state == ST_IDLE) begin
            w_cur_we    = i_we;
            w_cur_addr  = i_addr;
            w_cur_wdata = i_wdata;
            w_cur_be    = i_be;
        end else begin
            w_cur_we    = r_we;
            w_cur_addr  = r_addr;
            w_cur_wdata = r_wdata;
            w_cur_be    = r_be;
        end
        w_off      = w_cur_addr - BASE_ADDR;
        // BASE_ADDR is word-aligned, so the offset's low bits equal the address's.
        w_addr_err = (|w_off[1:0]) ||
                     (w_cur_addr < BASE_ADDR) ||
                     ({2'b00, w_off[31:2]} >= 32'(DEPTH));
        w_cur_err  = (r_state == ST_IDLE) ? w_addr_err : r_err;
        w_idx      = w_off[AW+1:2];
    end

    // Handshake FSM with latched request, wait counter and registered response.
    // r_live keeps the first edge after reset release from accepting, so the
    // zero-wait path can never write the RAM while reset is still asserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_live  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_err   <= 1'b0;
            o_ready <= 1'b0;
            o_err   <= 1'b0;
            o_rdata <= '0;
        end else begin
            r_live  <= 1'b1;
            o_ready <= 1'b0;
            o_err   <= 1'b0;
            if (w_enter_resp) begin
                o_ready <= 1'b1;
                o_err   <= w_cur_err;
                if (!w_cur_we) begin
                    o_rdata <= w_cur_err ? '0 : r_mem[w_idx];
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= i_we;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_be    <= i_be;
                        r_err   <= w_addr_err;
                        r_cnt   <= CNT_INIT;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-lane RAM write on the edge entering RESP; errored stores write nothing.
    always_ff @(posedge i_clk) begin
        if (w_enter_resp && w_cur_we && !w_cur_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_cur_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_handshake_responder.sv
// Self-checking bench for dmem_handshake_responder: directed vector table,
// multi-cycle corner sequences and randomized traffic against a word-array model.
module tb_dmem_handshake_responder;

    localparam int unsigned WAITC = 2;
    localparam int unsigned LAT   = WAITC + 1;
    localparam int unsigned NWORD = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be    = '0;
    logic        o_ready;
    logic [31:0] o_rdata;
    logic        o_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [NWORD];
    logic [31:0] m_last;

    always #5 clk = ~clk;

    dmem_handshake_responder #(
        .DEPTH      (NWORD),
        .WAIT_CYCLES(WAITC),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_req  (req),
        .i_we   (we),
        .i_addr (addr),
        .i_wdata(wdata),
        .i_be   (be),
        .o_ready(o_ready),
        .o_rdata(o_rdata),
        .o_err  (o_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Memory behaviour from the rules: aligned, in-range words only; stores
    // merge enabled bytes, loads return the word, stores leave rdata as it was.
    function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [3:0] b, output logic [31:0] erd, output logic eerr);
        eerr = ((a % 4) != 0) || (a >= NWORD * 4);
        if (w) begin
            if (!eerr) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) mdl[a[9:2]][8*k +: 8] = wd[8*k +: 8];
                end
            end
            erd = m_last;
        end else begin
            erd    = eerr ? 32'h0 : mdl[a[9:2]];
            m_last = erd;
        end
    endfunction

    // One complete transaction: latency, err, rdata and one-cycle pulse width.
    task automatic txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic [31:0] erd, input logic eerr);
        int lat;
        bit got;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd; be = b;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (o_ready) got = 1'b1;
        end
        req = 1'b0;
        chk($sformatf("%s ready_seen", nm), 32'(got), 32'd1);
        if (got) begin
            chk($sformatf("%s latency", nm), 32'(lat), 32'(LAT));
            chk($sformatf("%s err", nm), 32'(o_err), 32'(eerr));
            chk($sformatf("%s rdata", nm), o_rdata, erd);
            @(negedge clk);
            chk($sformatf("%s pulse_width", nm), 32'(o_ready), 32'd0);
            chk($sformatf("%s err_idle", nm), 32'(o_err), 32'd0);
        end
    endtask

    task automatic mtxn(input string nm, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] erd;
        logic eerr;
        model(w, a, wd, b, erd, eerr);
        txn(nm, w, a, wd, b, erd, eerr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] erd;
        logic        eerr;
        int          k;
        int          cyc;
        int          last;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_exp  [3];

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0010, 32'h0000_5500, 4'h2, 32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_55EF, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        tbl[5]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1};
        tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h1122_3344, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_C0DE, 4'hF, 32'h1122_3344, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h0BAD_C0DE, 1'b0};
        tbl[10] = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        tbl[11] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        tbl[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_55EF, 1'b0};
        tbl[13] = '{1'b1, 32'h0000_0002, 32'h1234_5678, 4'hF, 32'hDEAD_55EF, 1'b1};
        tbl[14] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h1122_3344, 1'b0};
        tbl[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};

        // Reset values, then an idle stretch with no request.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ready", 32'(o_ready), 32'd0);
        chk("reset err", 32'(o_err), 32'd0);
        chk("reset rdata", o_rdata, 32'h0);
        rst_n  = 1'b1;
        m_last = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d ready", i), 32'(o_ready), 32'd0);
        end

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, erd, eerr);
            txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                tbl[i].erd, tbl[i].eerr);
        end

        // Back-to-back loads with i_req held high throughout.
        mtxn("pre4", 1'b1, 32'h4, 32'h5555_0004, 4'hF);
        mtxn("pre8", 1'b1, 32'h8, 32'h6666_0008, 4'hF);
        b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
        for (int i = 0; i < 3; i++) model(1'b0, b2b_addr[i], 32'h0, 4'h0, b2b_exp[i], eerr);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = b2b_addr[0]; be = 4'hF;
        k = 0; cyc = 0; last = 0;
        while (k < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (o_ready) begin
                chk($sformatf("b2b%0d rdata", k), o_rdata, b2b_exp[k]);
                if (k == 0) chk("b2b first latency", 32'(cyc), 32'(LAT));
                else        chk($sformatf("b2b%0d spacing", k), 32'(cyc - last), 32'(WAITC + 2));
                last = cyc;
                k++;
                if (k < 3) addr = b2b_addr[k];
                else       req = 1'b0;
                @(negedge clk);
                cyc++;
                chk($sformatf("b2b%0d width", k - 1), 32'(o_ready), 32'd0);
            end
        end
        req = 1'b0;
        chk("b2b pulses", 32'(k), 32'd3);

        // Reset in the middle of WAIT aborts the store.
        mtxn("pre20", 1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        chk("midrst ready", 32'(o_ready), 32'd0);
        chk("midrst rdata", o_rdata, 32'h0);
        rst_n  = 1'b1;
        m_last = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("midrst post%0d ready", i), 32'(o_ready), 32'd0);
        end
        mtxn("midrst load20", 1'b0, 32'h20, 32'h0, 4'h0);

        // Fill every word, then random mixed traffic.
        for (int i = 0; i < int'(NWORD); i++) begin
            mtxn($sformatf("fill%0d", i), 1'b1, 32'(i * 4), $urandom, 4'hF);
        end
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 1) a = 32'h400 + ($urandom & 32'hFFFF_FBFC);
            else               a = {22'h0, 8'($urandom), 2'b00};
            mtxn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
